// File: rtl/cla_seq_add_ctrl.sv
// cla_seq_add_ctrl: time-shares one 4-bit CLA block over N-bit operands, LSB slice first.
// Optional subtract mode under `CLA_SEQ_SUB_EN.
module cla_seq_add_ctrl #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef CLA_SEQ_SUB_EN
  input  logic         sub,
`endif
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         C_in,
  output logic [N-1:0] Z,
  output logic         C_out,
  output logic         overflow,
  output logic         busy,
  output logic         done,
  output logic [3:0]   blk_X,
  output logic [3:0]   blk_Y,
  output logic         blk_C_in,
  input  logic [3:0]   blk_Z,
  input  logic         blk_C_out,
  input  logic         blk_ovf
);
  localparam int S = N / 4;
  localparam int IW = $clog2(S);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic carry, sub_q, last, accept;
`ifdef CLA_SEQ_SUB_EN
  logic sub_in;
  assign sub_in = sub;
`else
  logic sub_in;
  assign sub_in = 1'b0;
`endif
  assign last = idx == IW'(S - 1);
  assign accept = start && state != RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign blk_X = a_q[4*idx +: 4];
  assign blk_Y = sub_q ? ~b_q[4*idx +: 4] : b_q[4*idx +: 4];
  assign blk_C_in = carry;
  always_comb begin
    state_n = state;
    state_n = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      sub_q    <= 1'b0;
      Z        <= '0;
      C_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q   <= X;
        b_q   <= Y;
        sub_q <= sub_in;
        idx   <= '0;
        carry <= sub_in | C_in;
      end else if (state == RUN) begin
        Z[4*idx +: 4] <= blk_Z;
        carry <= blk_C_out;
        idx   <= last ? '0 : idx + 1'b1;
        if (last) begin
          C_out    <= blk_C_out;
          overflow <= blk_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// tb_cla_seq_add_ctrl: directed checks of the sequencer driving a behavioural 4-bit CLA.
module tb_cla_seq_add_ctrl;
  localparam int N = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, C_in = 1'b0, sub = 1'b0;
  logic [N-1:0] X = '0, Y = '0, Z;
  logic C_out, overflow, busy, done;
  logic [3:0] blk_X, blk_Y, blk_Z;
  logic blk_C_in, blk_C_out, blk_ovf;
  int n_cmp = 0, n_err = 0;

  cla_seq_add_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef CLA_SEQ_SUB_EN
    .sub(sub),
`endif
    .X(X), .Y(Y), .C_in(C_in), .Z(Z), .C_out(C_out), .overflow(overflow),
    .busy(busy), .done(done), .blk_X(blk_X), .blk_Y(blk_Y), .blk_C_in(blk_C_in),
    .blk_Z(blk_Z), .blk_C_out(blk_C_out), .blk_ovf(blk_ovf)
  );

  // 4-bit carry-lookahead block on the blk_* ports
  logic [4:0] c;
  always_comb begin
    c = '0;
    c[0] = blk_C_in;
    for (int i = 0; i < 4; i++) c[i+1] = (blk_X[i] & blk_Y[i]) | ((blk_X[i] ^ blk_Y[i]) & c[i]);
    blk_Z = blk_X ^ blk_Y ^ c[3:0];
    blk_C_out = c[4];
    blk_ovf = c[4] ^ c[3];
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, output int k);
    k = 0;
    while (!done && k < 10) begin
      step();
      k++;
    end
    chk({tag, ":latency"}, 32'(k), 32'd4);
  endtask

  task automatic run_add(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic [15:0] ez, input logic ec, input logic eo);
    int k;
    X = x; Y = y; C_in = ci; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ":busy"}, busy, 1'b1);
    chk({tag, ":blk_X0"}, blk_X, x[3:0]);
    wait_done(tag, k);
    chk({tag, ":Z"}, Z, ez);
    chk({tag, ":C_out"}, C_out, ec);
    chk({tag, ":ovf"}, overflow, eo);
    step();
    chk({tag, ":done_pulse"}, done, 1'b0);
    chk({tag, ":idle"}, busy, 1'b0);
  endtask

  initial begin
    int k;
    step();
    step();
    chk("rst:Z", Z, 16'h0);
    chk("rst:C_out", C_out, 1'b0);
    chk("rst:ovf", overflow, 1'b0);
    chk("rst:busy", busy, 1'b0);
    chk("rst:done", done, 1'b0);
    chk("rst:blk", {blk_X, blk_Y, blk_C_in}, 9'h0);
    rst = 1'b0;
    step();
    run_add("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_add("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_add("t3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add("t3c", 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0);
    // ignored start during RUN, then back-to-back start in DONE
    X = 16'h0001; Y = 16'h0001; C_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    X = 16'h00FF; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!done && k < 10) begin step(); k++; end
    chk("t4:done_seen", done, 1'b1);
    chk("t4:Z", Z, 16'h0002);
    X = 16'h0003; Y = 16'h0004; start = 1'b1;
    step();
    start = 1'b0;
    chk("t4b:busy", busy, 1'b1);
    chk("t4b:done", done, 1'b0);
    wait_done("t4b", k);
    chk("t4b:Z", Z, 16'h0007);
    step();
    // reset mid-RUN
    X = 16'h1111; Y = 16'h1111; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5:busy", busy, 1'b0);
    chk("t5:done", done, 1'b0);
    chk("t5:Z", Z, 16'h0);
    chk("t5:C_out", C_out, 1'b0);
    chk("t5:blk", {blk_X, blk_Y, blk_C_in}, 9'h0);
    k = 0;
    for (int i = 0; i < 6; i++) begin step(); if (done) k++; end
    chk("t5:no_done", 32'(k), 32'd0);
`ifdef CLA_SEQ_SUB_EN
    sub = 1'b1;
    run_add("t6a", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_add("t6b", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
    sub = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
